frame_sequencer: RTL and testbench

//  Per-frame scheduler for the game datapath while the game FSM is in RUN.

---
 rtl/frame_sequencer_pkg.sv | 22 ++
 rtl/frame_sequencer_if.sv | 27 ++
 rtl/frame_sequencer_prescaler.sv | 40 ++++
 rtl/frame_sequencer.sv | 162 ++++++++++++++++
 tb/tb_frame_sequencer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_sequencer_pkg.sv
// Shared types and constants for the game datapath: game-level and
// frame-level state encodings plus the score width.
package frame_sequencer_pkg;

    localparam int SCORE_W = 7;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OVER,
        WIN
    } state_t;

    typedef enum logic [2:0] {
        WAIT_TICK,
        UPDATE,
        WAIT_PHYS,
        SCORE,
        DRAW
    } seq_state_t;

endpackage

// File: rtl/frame_sequencer_if.sv
// Frame handshake bundle: object-update strobe, physics result, and the
// LCD redraw request/acknowledge pair.
interface frame_sequencer_if;

    logic obj_update;
    logic phys_done;
    logic collide;
    logic lcd_req;
    logic lcd_ack;

    modport master (
        output obj_update,
        output lcd_req,
        input  phys_done,
        input  collide,
        input  lcd_ack
    );

    modport slave (
        input  obj_update,
        input  lcd_req,
        output phys_done,
        output collide,
        output lcd_ack
    );

endinterface

// File: rtl/frame_sequencer_prescaler.sv
// Frame tick prescaler: one-cycle tick every TICK_DIV enabled cycles,
// counter held at zero while disabled so each enable starts a full period.
module frame_prescaler #(
    parameter int TICK_DIV = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        cnt_d = '0;
        if (en_i) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Gated by en_i so the cycle run_en falls never produces a stray tick.
    assign tick_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame scheduler for the game datapath: tick -> object update -> wait for
// physics -> score -> LCD redraw, with collision/score_max pulses for the game FSM.
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int TICK_DIV    = 250000,
    parameter int SCORE_EVERY = 8,
    parameter int SCORE_MAX   = 99,
    parameter int PHYS_TMO    = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run_en_i,
    frame_sequencer_if.master  bus,
    output logic               collision_o,
    output logic               score_max_o,
    output logic [SCORE_W-1:0] score_o,
    output logic               busy_o,
    output logic               overrun_o,
    output logic               fault_o
);

    localparam int TMR_W = $clog2(PHYS_TMO + 1);
    localparam int FC_W  = (SCORE_EVERY > 1) ? $clog2(SCORE_EVERY) : 1;

    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(PHYS_TMO);
    localparam logic [FC_W-1:0]    FC_LAST  = FC_W'(SCORE_EVERY - 1);
    localparam logic [SCORE_W-1:0] SMAX     = SCORE_W'(SCORE_MAX);

    seq_state_t         state_q;
    logic               run_en_q;
    logic [TMR_W-1:0]   timer_q;
    logic [FC_W-1:0]    frame_cnt_q;
    logic [SCORE_W-1:0] score_q;
    logic               obj_update_q;
    logic               lcd_req_q;
    logic               collision_q;
    logic               score_max_q;
    logic               overrun_q;
    logic               fault_q;

    logic tick;
    logic run_rise;

    frame_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .en_i   (run_en_i),
        .tick_o (tick)
    );

    assign run_rise = run_en_i && !run_en_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= WAIT_TICK;
            run_en_q     <= 1'b0;
            timer_q      <= '0;
            frame_cnt_q  <= '0;
            score_q      <= '0;
            obj_update_q <= 1'b0;
            lcd_req_q    <= 1'b0;
            collision_q  <= 1'b0;
            score_max_q  <= 1'b0;
            overrun_q    <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            run_en_q     <= run_en_i;
            obj_update_q <= 1'b0;
            collision_q  <= 1'b0;
            score_max_q  <= 1'b0;

            // A new run starts clean; a tick that finds the frame still busy is dropped.
            if (run_rise) begin
                score_q     <= '0;
                frame_cnt_q <= '0;
                overrun_q   <= 1'b0;
                fault_q     <= 1'b0;
            end else if (tick && state_q != WAIT_TICK) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                WAIT_TICK: begin
                    if (tick) begin
                        obj_update_q <= 1'b1;
                        state_q      <= UPDATE;
                    end
                end

                UPDATE: begin
                    timer_q <= '0;
                    state_q <= run_en_i ? WAIT_PHYS : WAIT_TICK;
                end

                WAIT_PHYS: begin
                    if (!run_en_i) begin
                        state_q <= WAIT_TICK;
                    end else if (bus.phys_done) begin
                        if (bus.collide) begin
                            collision_q <= 1'b1;
                            lcd_req_q   <= 1'b1;
                            state_q     <= DRAW;
                        end else begin
                            state_q <= SCORE;
                        end
                    end else if (timer_q == TMR_LAST) begin
                        fault_q <= 1'b1;
                        state_q <= WAIT_TICK;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                SCORE: begin
                    if (!run_en_i) begin
                        state_q <= WAIT_TICK;
                    end else begin
                        // Saturating score; score_max fires only on the step into SMAX.
                        if (frame_cnt_q == FC_LAST) begin
                            frame_cnt_q <= '0;
                            if (score_q < SMAX) begin
                                score_q <= score_q + 1'b1;
                                if (score_q == SMAX - 1'b1) begin
                                    score_max_q <= 1'b1;
                                end
                            end
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end
                        lcd_req_q <= 1'b1;
                        state_q   <= DRAW;
                    end
                end

                DRAW: begin
                    // Held through run_en loss: the LCD driver must see its ack consumed.
                    if (bus.lcd_ack) begin
                        lcd_req_q <= 1'b0;
                        state_q   <= WAIT_TICK;
                    end
                end

                default: begin
                    state_q <= WAIT_TICK;
                end
            endcase
        end
    end

    assign bus.obj_update = obj_update_q;
    assign bus.lcd_req    = lcd_req_q;
    assign collision_o    = collision_q;
    assign score_max_o    = score_max_q;
    assign score_o        = score_q;
    assign busy_o         = (state_q != WAIT_TICK);
    assign overrun_o      = overrun_q;
    assign fault_o        = fault_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomized bench for frame_sequencer: a responder plays physics and LCD
// driver, a frame-level score model feeds a scoreboard checked on each redraw.
module tb_frame_sequencer;
    import frame_sequencer_pkg::*;

    localparam int TICK_DIV    = 16;
    localparam int SCORE_EVERY = 8;
    localparam int SCORE_MAX   = 99;
    localparam int PHYS_TMO    = 255;

    logic               clk = 1'b0;
    logic               reset;
    logic               run_en;
    logic               collision;
    logic               score_max;
    logic [SCORE_W-1:0] score;
    logic               busy;
    logic               overrun;
    logic               fault;

    frame_sequencer_if bus ();

    frame_sequencer #(
        .TICK_DIV    (TICK_DIV),
        .SCORE_EVERY (SCORE_EVERY),
        .SCORE_MAX   (SCORE_MAX),
        .PHYS_TMO    (PHYS_TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run_en_i    (run_en),
        .bus         (bus),
        .collision_o (collision),
        .score_max_o (score_max),
        .score_o     (score),
        .busy_o      (busy),
        .overrun_o   (overrun),
        .fault_o     (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit coll;
        bit smax;
        int score;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: frames survived since the last run start.
    int survived = 0;
    int redraws  = 0;
    int coll_cnt = 0;
    int smax_cnt = 0;

    // Responder controls and state.
    int phys_dly      = 3;
    int ack_dly       = 2;
    int collide_pct   = 0;
    bit force_collide = 1'b0;
    bit phys_hold     = 1'b0;
    bit ack_hold      = 1'b0;
    bit stray_req     = 1'b0;
    int pc            = 0;
    int ac            = 0;
    bit req_seen      = 1'b0;
    bit cval;
    bit prev_req      = 1'b0;
    exp_t e_mon;
    exp_t e_rsp;

    function automatic int model_score();
        int s;
        s = survived / SCORE_EVERY;
        return (s > SCORE_MAX) ? SCORE_MAX : s;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Responder: physics and LCD driver with randomized latencies.
    initial begin
        bus.phys_done = 1'b0;
        bus.collide   = 1'b0;
        bus.lcd_ack   = 1'b0;
        forever begin
            @(negedge clk);
            bus.phys_done = 1'b0;
            bus.collide   = 1'b0;
            bus.lcd_ack   = 1'b0;
            if (!reset) begin
                pc       = 0;
                ac       = 0;
                req_seen = 1'b0;
            end else begin
                if (stray_req) begin
                    bus.phys_done = 1'b1;
                    bus.collide   = 1'b1;
                    bus.lcd_ack   = 1'b1;
                    stray_req     = 1'b0;
                end
                if (pc > 0) begin
                    pc--;
                    if (pc == 0 && !phys_hold) begin
                        cval          = force_collide || (int'($urandom_range(99)) < collide_pct);
                        force_collide = 1'b0;
                        bus.phys_done = 1'b1;
                        bus.collide   = cval;
                        if (cval) begin
                            e_rsp = '{coll: 1'b1, smax: 1'b0, score: model_score()};
                        end else begin
                            survived++;
                            e_rsp = '{coll: 1'b0, smax: (survived == SCORE_MAX * SCORE_EVERY),
                                      score: model_score()};
                        end
                        exp_q.push_back(e_rsp);
                    end
                end
                if (bus.obj_update) begin
                    pc = (phys_dly > 0) ? phys_dly : int'($urandom_range(4, 1));
                end
                if (ac > 0 && !(ac == 1 && ack_hold)) begin
                    ac--;
                    if (ac == 0) begin
                        bus.lcd_ack = 1'b1;
                    end
                end
                if (bus.lcd_req && !req_seen) begin
                    req_seen = 1'b1;
                    ac = (ack_dly > 0) ? ack_dly : int'($urandom_range(4, 1));
                end
                if (!bus.lcd_req) begin
                    req_seen = 1'b0;
                end
            end
        end
    end

    // Monitor: each new redraw request carries the frame's result.
    initial begin
        forever begin
            @(negedge clk);
            if (collision && score_max) begin
                check("collision_with_score_max", 1, 0);
            end
            if (bus.lcd_req && !prev_req) begin
                redraws++;
                if (exp_q.size() == 0) begin
                    check("redraw_expected", 0, 1);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("redraw_collision", collision, e_mon.coll);
                    check("redraw_score_max", score_max, e_mon.smax);
                    check("redraw_score", score, e_mon.score);
                end
            end else if (collision || score_max) begin
                check("stray_pulse", {collision, score_max}, 0);
            end
            if (collision) coll_cnt++;
            if (score_max) smax_cnt++;
            prev_req = bus.lcd_req;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_obj(input string name, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.obj_update && n < budget);
        if (!bus.obj_update) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic run_until(input int target, input int budget);
        int n;
        n = 0;
        while (!(survived >= target && exp_q.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("run_until_timeout", survived, target);
    endtask

    task automatic quiesce();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(!busy && pc == 0 && ac == 0 && exp_q.size() == 0 && !bus.lcd_req) && n < 200);
        if (n >= 200) check("quiesce_timeout", busy, 0);
    endtask

    task automatic wait_req(input logic level, input int budget);
        int n;
        n = 0;
        while (bus.lcd_req !== level && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.lcd_req !== level) check("lcd_req_wait_timeout", bus.lcd_req, level);
    endtask

    initial begin
        int n;
        int c0;
        int r0;

        reset  = 1'b0;
        run_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_obj_update", bus.obj_update, 0);
        check("reset_lcd_req", bus.lcd_req, 0);
        check("reset_collision", collision, 0);
        check("reset_score_max", score_max, 0);
        check("reset_score", score, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);
        check("reset_fault", fault, 0);

        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Fixed-latency frames: tick period and first score step.
        survived = 0;
        run_en   = 1'b1;
        wait_obj("first_obj_update", 100, n);
        check("first_obj_update_latency", n, TICK_DIV);
        wait_obj("second_obj_update", 100, n);
        check("obj_update_period", n, TICK_DIV);
        run_until(SCORE_EVERY, 1000);
        check("score_after_8_frames", score, 1);
        check("lcd_req_each_frame", redraws, SCORE_EVERY);

        // Randomized latencies and collisions.
        phys_dly    = 0;
        ack_dly     = 0;
        collide_pct = 25;
        run_until(60, 5000);
        check("score_random_phase", score, model_score());

        // Climb to 98, then across the saturation point.
        collide_pct = 5;
        run_until(SCORE_MAX * SCORE_EVERY - 1, 20000);
        check("score_before_max", score, SCORE_MAX - 1);
        check("no_score_max_yet", smax_cnt, 0);
        run_until(SCORE_MAX * SCORE_EVERY, 200);
        check("score_reaches_max", score, SCORE_MAX);
        check("score_max_pulsed_once", smax_cnt, 1);
        run_until(SCORE_MAX * SCORE_EVERY + 3 * SCORE_EVERY, 2000);
        check("score_saturated", score, SCORE_MAX);
        check("score_max_no_repulse", smax_cnt, 1);

        // Forced collision: one pulse, score unchanged, redraw still issued.
        collide_pct   = 0;
        c0            = coll_cnt;
        r0            = redraws;
        force_collide = 1'b1;
        n = 0;
        while ((force_collide || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("collision_pulse_count", coll_cnt, c0 + 1);
        check("collision_redraw", redraws, r0 + 1);
        check("collision_score_kept", score, SCORE_MAX);

        // Score held while run_en is low.
        quiesce();
        run_en = 1'b0;
        repeat (20) @(negedge clk);
        check("score_held_run_low", score, SCORE_MAX);
        check("idle_run_low", busy, 0);

        // Physics timeout.
        survived = 0;
        run_en   = 1'b1;
        repeat (2) @(negedge clk);
        check("score_cleared_on_run", score, 0);
        phys_hold = 1'b1;
        wait_obj("fault_obj_update", 100, n);
        n = 0;
        while (!fault && n < 400) begin
            @(negedge clk);
            n++;
        end
        phys_hold = 1'b0;
        check("fault_latency", n, PHYS_TMO + 2);
        check("fault_set", fault, 1);
        check("overrun_during_stall", overrun, 1);
        quiesce();
        run_en = 1'b0;
        @(negedge clk);
        survived = 0;
        run_en   = 1'b1;
        repeat (2) @(negedge clk);
        check("fault_cleared_on_run", fault, 0);
        check("overrun_cleared_on_run", overrun, 0);

        // Withheld ack: next tick finds DRAW busy.
        ack_hold = 1'b1;
        n = 0;
        while (!overrun && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("overrun_ack_withheld", overrun, 1);
        check("lcd_req_held_no_ack", bus.lcd_req, 1);
        ack_hold = 1'b0;
        quiesce();

        // Stray phys_done/lcd_ack while idle are ignored.
        c0        = coll_cnt;
        r0        = redraws;
        stray_req = 1'b1;
        repeat (3) @(negedge clk);
        check("stray_no_redraw", redraws, r0);
        check("stray_no_collision", coll_cnt, c0);

        // run_en drop in WAIT_PHYS aborts silently.
        quiesce();
        phys_hold = 1'b1;
        c0        = coll_cnt;
        wait_obj("abort_obj_update", 100, n);
        @(negedge clk);
        run_en = 1'b0;
        @(negedge clk);
        check("abort_wait_phys_idle", busy, 0);
        repeat (6) @(negedge clk);
        check("abort_no_lcd_req", bus.lcd_req, 0);
        check("abort_no_collision", coll_cnt, c0);
        check("abort_no_fault", fault, 0);
        phys_hold = 1'b0;

        // run_en drop in DRAW: request held until acknowledged.
        ack_hold = 1'b1;
        survived = 0;
        run_en   = 1'b1;
        wait_req(1'b1, 100);
        @(negedge clk);
        run_en = 1'b0;
        repeat (5) @(negedge clk);
        check("draw_held_lcd_req", bus.lcd_req, 1);
        check("draw_held_busy", busy, 1);
        ack_hold = 1'b0;
        wait_req(1'b0, 20);
        check("draw_done_idle", busy, 0);
        quiesce();

        // Asynchronous reset in the middle of DRAW.
        ack_hold = 1'b1;
        survived = 0;
        run_en   = 1'b1;
        wait_req(1'b1, 100);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_lcd_req", bus.lcd_req, 0);
        check("async_reset_busy", busy, 0);
        check("async_reset_score", score, 0);
        check("async_reset_overrun", overrun, 0);
        check("async_reset_fault", fault, 0);
        check("async_reset_obj_update", bus.obj_update, 0);
        exp_q.delete();
        ack_hold = 1'b0;
        run_en   = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
